// File: rtl/cr_axi4s_mstr_arb_if.sv
// Bus bundle for the AXI4-Stream master arbiter: per-channel show-ahead FIFO
// heads and pops on one side, the merged stream on the other.
interface cr_axi4s_mstr_arb_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 64,
  parameter int USER_W = 8
);
  localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH*DATA_W-1:0] in_tdata;
  logic [N_CH-1:0]        in_tlast;
  logic [N_CH*USER_W-1:0] in_tuser;
  logic [N_CH-1:0]        in_empty;
  logic [N_CH-1:0]        in_rd;
  logic                   ob_tready;
  logic                   ob_tvalid;
  logic [DATA_W-1:0]      ob_tdata;
  logic                   ob_tlast;
  logic [USER_W-1:0]      ob_tuser;
  logic [ID_W-1:0]        ob_tid;
  logic                   idle;

  // arbiter side
  modport master (
    input  in_tdata, in_tlast, in_tuser, in_empty, ob_tready,
    output in_rd, ob_tvalid, ob_tdata, ob_tlast, ob_tuser, ob_tid, idle
  );

  // FIFO / sink side
  modport slave (
    output in_tdata, in_tlast, in_tuser, in_empty, ob_tready,
    input  in_rd, ob_tvalid, ob_tdata, ob_tlast, ob_tuser, ob_tid, idle
  );
endinterface

// File: rtl/cr_axi4s_mstr_arb.sv
// Packet-locked round-robin arbiter merging N_CH show-ahead FIFOs into one
// AXI4-Stream. A 2-entry head/skid buffer decouples pops from ob_tready so
// in_rd never depends combinationally on the downstream ready.
module cr_axi4s_mstr_arb #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 64,
  parameter int USER_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  cr_axi4s_mstr_arb_if.master bus
);
  localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic [USER_W-1:0] user;
    logic [ID_W-1:0]   id;
  } beat_t;

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  logic [N_CH-1:0][DATA_W-1:0] ch_data;
  logic [N_CH-1:0][USER_W-1:0] ch_user;
  assign ch_data = bus.in_tdata;
  assign ch_user = bus.in_tuser;

  state_t          state_q, state_n;
  logic [ID_W-1:0] rr_q, rr_n, lock_q, lock_n, gnt;
  logic            gnt_vld, pop, drain;
  logic [1:0]      cnt_q;
  beat_t           head_q, skid_q, new_beat;
  int              idx;

  // grant: locked channel, else first non-empty from rr_q upward (wrapping);
  // scanning downward so the lowest offset wins as the last assignment
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    if (state_q == LOCK) begin
      gnt     = lock_q;
      gnt_vld = ~bus.in_empty[lock_q];
    end else begin
      for (int k = N_CH - 1; k >= 0; k--) begin
        idx = int'(rr_q) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!bus.in_empty[ID_W'(idx)]) begin
          gnt     = ID_W'(idx);
          gnt_vld = 1'b1;
        end
      end
    end
  end

  // pop only with buffer room; reset forces the pop strobe low
  assign pop   = rst_n & gnt_vld & (cnt_q != 2'd2);
  assign drain = (cnt_q != 2'd0) & bus.ob_tready;

  // one-hot pop strobe toward the granted FIFO
  always_comb begin
    bus.in_rd = '0;
    if (pop) bus.in_rd[gnt] = 1'b1;
  end

  assign new_beat = '{data: ch_data[gnt], last: bus.in_tlast[gnt],
                      user: ch_user[gnt], id: gnt};

  // head/skid buffer: pushes fill the tail, drains shift skid into head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      case ({pop, drain})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= new_beat;
          else               skid_q <= new_beat;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= skid_q;
          skid_q <= '0;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) head_q <= new_beat;
          else begin
            head_q <= skid_q;
            skid_q <= new_beat;
          end
        end
        default: ;
      endcase
    end
  end

  // state, lock channel and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      lock_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_n;
      lock_q  <= lock_n;
      rr_q    <= rr_n;
    end
  end

  // lock on a non-last pop, unlock and advance rr past g on a last pop
  always_comb begin
    state_n = state_q;
    lock_n  = lock_q;
    rr_n    = rr_q;
    if (pop) begin
      if (bus.in_tlast[gnt]) begin
        state_n = ARB;
        rr_n    = (int'(gnt) == N_CH - 1) ? '0 : gnt + 1'b1;
      end else begin
        state_n = LOCK;
        lock_n  = gnt;
      end
    end
  end

  assign bus.ob_tvalid = (cnt_q != 2'd0);
  assign bus.ob_tdata  = bus.ob_tvalid ? head_q.data : '0;
  assign bus.ob_tlast  = bus.ob_tvalid & head_q.last;
  assign bus.ob_tuser  = bus.ob_tvalid ? head_q.user : '0;
  assign bus.ob_tid    = bus.ob_tvalid ? head_q.id   : '0;
  assign bus.idle      = (cnt_q == 2'd0) & (state_q == ARB) & (&bus.in_empty);
endmodule

// File: tb/tb_cr_axi4s_mstr_arb.sv
// Bench for cr_axi4s_mstr_arb: source FIFOs are queues of packets, and a
// beat-queue reference model predicts pops, stream beats and idle every cycle.
module tb_cr_axi4s_mstr_arb;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int UW = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [UW-1:0] user;
    int            id;
  } tbeat_t;

  typedef struct {
    logic [N-1:0] emp;
    logic [N-1:0] exp_rd;
    logic         exp_idle;
  } vec_t;

  logic clk, rst_n;
  cr_axi4s_mstr_arb_if #(.N_CH(N), .DATA_W(DW), .USER_W(UW)) bus();
  cr_axi4s_mstr_arb #(.N_CH(N), .DATA_W(DW), .USER_W(UW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  tbeat_t srcq [N][$];
  tbeat_t mq[$];
  int     out_tid[$];
  int     m_lock, m_rr;
  logic [N-1:0] gate;
  logic ready;
  logic [N-1:0] last_rd;
  logic last_tv, last_tl;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic avail(int c);
    return (srcq[c].size() > 0) && !gate[c];
  endfunction

  task automatic add_pkt(int c, int len);
    tbeat_t x;
    for (int b = 0; b < len; b++) begin
      x.data = {$urandom, $urandom};
      x.last = (b == len - 1);
      x.user = UW'($urandom);
      x.id   = c;
      srcq[c].push_back(x);
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) srcq[i].delete();
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.in_empty[i] = !avail(i);
      if (srcq[i].size() > 0) begin
        bus.in_tdata[i*DW +: DW] = srcq[i][0].data;
        bus.in_tlast[i]          = srcq[i][0].last;
        bus.in_tuser[i*UW +: UW] = srcq[i][0].user;
      end else begin
        bus.in_tdata[i*DW +: DW] = '0;
        bus.in_tlast[i]          = 1'b0;
        bus.in_tuser[i*UW +: UW] = '0;
      end
    end
    bus.ob_tready = ready;
  endtask

  // one clock of stimulus, prediction, comparison and model update
  task automatic step();
    int ch;
    logic [N-1:0] erd;
    logic [75:0] eob;
    logic aemp;
    tbeat_t b;
    drive();
    @(negedge clk);
    ch = -1;
    if (m_lock >= 0) begin
      if (avail(m_lock)) ch = m_lock;
    end else begin
      for (int k = 0; k < N; k++)
        if (ch < 0 && avail((m_rr + k) % N)) ch = (m_rr + k) % N;
    end
    erd = (ch >= 0 && mq.size() < 2) ? N'(1 << ch) : '0;
    eob = '0;
    if (mq.size() > 0) eob = {1'b1, mq[0].last, 2'(mq[0].id), mq[0].user, mq[0].data};
    aemp = 1'b1;
    for (int i = 0; i < N; i++) if (avail(i)) aemp = 1'b0;
    chk("in_rd", 128'(bus.in_rd), 128'(erd));
    chk("ob_beat", 128'({bus.ob_tvalid, bus.ob_tlast, bus.ob_tid, bus.ob_tuser, bus.ob_tdata}), 128'(eob));
    chk("idle", 128'(bus.idle), 128'(mq.size() == 0 && m_lock < 0 && aemp));
    last_rd = bus.in_rd;
    last_tv = bus.ob_tvalid;
    last_tl = bus.ob_tlast;
    if (bus.ob_tvalid && ready) out_tid.push_back(int'(bus.ob_tid));
    if (mq.size() > 0 && ready) void'(mq.pop_front());
    if (erd != '0) begin
      b = srcq[ch][0];
      b.id = ch;
      mq.push_back(b);
      if (b.last) begin m_lock = -1; m_rr = (ch + 1) % N; end
      else m_lock = ch;
    end
    for (int i = 0; i < N; i++)
      if (bus.in_rd[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    @(posedge clk);
    #1;
  endtask

  // reset from a point away from the active edge; sources are left alone
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_tvalid", 128'(bus.ob_tvalid), 128'(0));
    chk("rst_in_rd", 128'(bus.in_rd), 128'(0));
    mq.delete();
    m_lock = -1;
    m_rr   = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain_all(int max_cyc);
    logic done;
    done = 1'b0;
    ready = 1'b1;
    gate = '0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      step();
      done = (mq.size() == 0);
      for (int i = 0; i < N; i++) if (srcq[i].size() > 0) done = 1'b0;
    end
    chk("drained", 128'(done), 128'(1));
  endtask

  vec_t vt[6];
  int pops, cnt3, nogap, code;
  logic [3:0] tvs, tls;

  initial begin
    vt[0] = '{emp: 4'b1111, exp_rd: 4'b0000, exp_idle: 1'b1};
    vt[1] = '{emp: 4'b1110, exp_rd: 4'b0001, exp_idle: 1'b0};
    vt[2] = '{emp: 4'b0101, exp_rd: 4'b0010, exp_idle: 1'b0};
    vt[3] = '{emp: 4'b0111, exp_rd: 4'b1000, exp_idle: 1'b0};
    vt[4] = '{emp: 4'b0000, exp_rd: 4'b0001, exp_idle: 1'b0};
    vt[5] = '{emp: 4'b1011, exp_rd: 4'b0100, exp_idle: 1'b0};

    rst_n = 1'b0; gate = '0; ready = 1'b0;
    m_lock = -1; m_rr = 0;
    clear_src();
    drive();
    #12;
    chk("reset_ob", 128'({bus.ob_tvalid, bus.ob_tlast, bus.ob_tid, bus.ob_tuser, bus.ob_tdata}), 128'(0));
    chk("reset_in_rd", 128'(bus.in_rd), 128'(0));
    chk("reset_idle", 128'(bus.idle), 128'(1));
    ready = 1'b1;
    add_pkt(0, 1);
    drive();
    #1;
    chk("reset_no_pop", 128'(bus.in_rd), 128'(0));
    chk("reset_idle_busy", 128'(bus.idle), 128'(0));
    clear_src();
    drive();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // arbitration from channel 0 straight out of reset
    foreach (vt[v]) begin
      do_reset();
      clear_src();
      for (int i = 0; i < N; i++) if (!vt[v].emp[i]) add_pkt(i, 1);
      drive();
      @(negedge clk);
      chk("vec_in_rd", 128'(bus.in_rd), 128'(vt[v].exp_rd));
      chk("vec_idle", 128'(bus.idle), 128'(vt[v].exp_idle));
      chk("vec_tvalid", 128'(bus.ob_tvalid), 128'(0));
      clear_src();
      drive();
    end

    // single 3-beat packet: 1-cycle latency, back-to-back beats
    do_reset();
    clear_src();
    add_pkt(0, 3);
    ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      tvs[k] = last_tv;
      tls[k] = last_tl;
    end
    chk("latency_tvalid", 128'(tvs), 128'(4'b1110));
    chk("latency_tlast", 128'(tls), 128'(4'b1000));
    drain_all(20);

    // two 2-beat packets on ch0 and ch2, then rr must point at ch3
    do_reset();
    clear_src();
    out_tid.delete();
    add_pkt(0, 2);
    add_pkt(2, 2);
    drain_all(40);
    code = -1;
    if (out_tid.size() == 4) code = out_tid[0]*1000 + out_tid[1]*100 + out_tid[2]*10 + out_tid[3];
    chk("rr_order", 128'(code), 128'(22));
    add_pkt(0, 1);
    add_pkt(3, 1);
    step();
    chk("rr_ptr_3", 128'(last_rd), 128'(4'b1000));
    drain_all(20);

    // backpressure: exactly two pops, then stall with stable outputs
    do_reset();
    clear_src();
    add_pkt(1, 8);
    ready = 1'b0;
    pops = 0;
    repeat (6) begin
      step();
      if (last_rd != '0) pops++;
    end
    chk("bp_pops", 128'(pops), 128'(2));
    drain_all(40);

    // lock holds through an empty locked channel
    do_reset();
    clear_src();
    add_pkt(1, 3);
    add_pkt(3, 2);
    ready = 1'b1;
    step();
    chk("lock_first", 128'(last_rd), 128'(4'b0010));
    gate[1] = 1'b1;
    cnt3 = 0;
    repeat (5) begin
      step();
      if (last_rd[3]) cnt3++;
    end
    chk("lock_no_ch3", 128'(cnt3), 128'(0));
    drain_all(40);

    // steady pop+drain at occupancy 1
    do_reset();
    clear_src();
    add_pkt(2, 12);
    ready = 1'b1;
    step();
    nogap = 0;
    repeat (10) begin
      step();
      if (last_tv && last_rd != '0) nogap++;
    end
    chk("stream_nogap", 128'(nogap), 128'(10));
    drain_all(20);

    // reset mid-packet with a full buffer
    do_reset();
    clear_src();
    add_pkt(1, 6);
    ready = 1'b0;
    repeat (3) step();
    do_reset();
    add_pkt(0, 1);
    ready = 1'b1;
    step();
    chk("post_rst_ch0", 128'(last_rd), 128'(4'b0001));
    drain_all(40);

    // random traffic with gaps and backpressure
    do_reset();
    clear_src();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() < 4 && $urandom_range(0, 7) == 0) add_pkt(i, $urandom_range(1, 4));
        gate[i] = ($urandom_range(0, 3) == 0);
      end
      ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain_all(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
